// File: rtl/spi_xfer_ctrl.sv
// SPI master byte-transfer controller.
// Sequences sck/mosi/ss_n from the CTRL/INTCTRL fields, assembles the received
// byte from miso, and returns RDATA/IF/WRCOL hardware updates to the CSR block.
//
// state | meaning
// IDLE  | bus parked: sck follows CPOL, ss_n high, waiting for a DATA write
// SHIFT | 16 sck half-periods in progress, bits shifted out and sampled
// DONE  | one cycle: received byte and IF handed to the register block
module spi_xfer_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_enable,
  input  logic              ctrl_master,
  input  logic [1:0]        ctrl_mode,
  input  logic [1:0]        ctrl_prescaler,
  input  logic              ctrl_clk2x,
  input  logic              ctrl_dord,
  input  logic [1:0]        intctrl_intlvl,
  input  logic              status_if,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rdata_next,
  output logic              rdata_we,
  output logic              if_next,
  output logic              if_we,
  output logic              wrcol_next,
  output logic              wrcol_we,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              ss_n,
  output logic              irq
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [6:0]          hcnt;     // down-counter to the next sck edge
  logic [6:0]          hm1_q;    // latched half-period minus one
  logic [3:0]          ecnt;     // sck edges already generated
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                cpol_q;
  logic                cpha_q;
  logic                dord_q;

  logic                run_ok;
  logic                start;
  logic                tick;
  logic                lead;
  logic                sample_now;
  logic                drive_now;
  logic [2:0]          out_pos;
  logic [2:0]          out_idx;
  logic [2:0]          first_idx;
  logic [DATA_W-1:0]   rx_shift;

  // Half-period minus one, so a terminal count of zero lands on edge k*H.
  function automatic logic [6:0] half_m1(input logic [1:0] presc, input logic c2x);
    logic [6:0] h;
    case (presc)
      2'd0:    h = c2x ? 7'd0  : 7'd1;
      2'd1:    h = c2x ? 7'd3  : 7'd7;
      2'd2:    h = c2x ? 7'd15 : 7'd31;
      default: h = c2x ? 7'd31 : 7'd63;
    endcase
    return h;
  endfunction

  assign if_next    = 1'b1;
  assign wrcol_next = 1'b1;

  // Interrupt is a pure function of the register fields; IF clearing lives in the CSR block.
  assign irq = status_if & (intctrl_intlvl != 2'd0);

  // Edge classification and bit selection for the edge about to be generated.
  always_comb begin
    run_ok     = ctrl_enable & ctrl_master;
    start      = tx_wr & run_ok;
    tick       = (hcnt == 7'd0);
    lead       = ~ecnt[0];
    sample_now = lead ^ cpha_q;
    // CPHA=0 preloads bit 0 at start, so the trailing edge after the last sample drives nothing.
    drive_now  = cpha_q ? lead : (~lead & (ecnt != 4'd15));
    out_pos    = cpha_q ? ecnt[3:1] : ecnt[3:1] + 3'd1;
    out_idx    = dord_q ? out_pos : 3'd7 - out_pos;
    first_idx  = ctrl_dord ? 3'd0 : 3'd7;
    rx_shift   = dord_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
  end

  // Transfer FSM with all pad and register-update outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      hm1_q      <= '0;
      ecnt       <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      dord_q     <= 1'b0;
      rdata_next <= '0;
      rdata_we   <= 1'b0;
      if_we      <= 1'b0;
      wrcol_we   <= 1'b0;
      busy       <= 1'b0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      ss_n       <= 1'b1;
    end else begin
      rdata_we <= 1'b0;
      if_we    <= 1'b0;
      wrcol_we <= 1'b0;
      case (state)
        IDLE: begin
          sck  <= ctrl_mode[1];
          ss_n <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            state  <= SHIFT;
            tx_q   <= tx_data;
            rx_q   <= '0;
            cpol_q <= ctrl_mode[1];
            cpha_q <= ctrl_mode[0];
            dord_q <= ctrl_dord;
            hm1_q  <= half_m1(ctrl_prescaler, ctrl_clk2x);
            hcnt   <= half_m1(ctrl_prescaler, ctrl_clk2x);
            ecnt   <= '0;
            busy   <= 1'b1;
            ss_n   <= 1'b0;
            if (!ctrl_mode[0]) mosi <= tx_data[first_idx];
          end
        end
        SHIFT: begin
          if (tx_wr) wrcol_we <= 1'b1;
          if (!run_ok) begin
            state <= IDLE;
            sck   <= cpol_q;
            ss_n  <= 1'b1;
            busy  <= 1'b0;
          end else if (tick) begin
            hcnt <= hm1_q;
            sck  <= ~sck;
            ecnt <= ecnt + 4'd1;
            if (sample_now) rx_q <= rx_shift;
            if (drive_now) mosi <= tx_q[out_idx];
            if (ecnt == 4'd15) begin
              state      <= DONE;
              rdata_we   <= 1'b1;
              if_we      <= 1'b1;
              rdata_next <= sample_now ? rx_shift : rx_q;
            end
          end else begin
            hcnt <= hcnt - 7'd1;
          end
        end
        DONE: begin
          if (tx_wr) wrcol_we <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
          ss_n  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: directed scenarios plus randomized
// transfers against a cycle-arithmetic reference of the SPI timing rules.
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl_enable, ctrl_master, ctrl_clk2x, ctrl_dord;
  logic [1:0] ctrl_mode, ctrl_prescaler, intctrl_intlvl;
  logic       status_if, tx_wr, miso;
  logic [7:0] tx_data;
  logic [7:0] rdata_next;
  logic       rdata_we, if_next, if_we, wrcol_next, wrcol_we;
  logic       busy, sck, mosi, ss_n, irq;

  int n_chk  = 0;
  int n_fail = 0;
  int htab[8] = '{2, 8, 32, 64, 1, 4, 16, 32};

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .ctrl_enable(ctrl_enable), .ctrl_master(ctrl_master),
    .ctrl_mode(ctrl_mode), .ctrl_prescaler(ctrl_prescaler),
    .ctrl_clk2x(ctrl_clk2x), .ctrl_dord(ctrl_dord),
    .intctrl_intlvl(intctrl_intlvl), .status_if(status_if),
    .tx_wr(tx_wr), .tx_data(tx_data),
    .rdata_next(rdata_next), .rdata_we(rdata_we),
    .if_next(if_next), .if_we(if_we),
    .wrcol_next(wrcol_next), .wrcol_we(wrcol_we),
    .busy(busy), .sck(sck), .mosi(mosi), .miso(miso),
    .ss_n(ss_n), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer; n counts posedges since the tx_wr sampling edge (E0).
  // coll_at/abort_at/rst_at name the edge at which that event is sampled (-1 = none).
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rxb, input logic [1:0] mode,
                      input logic [1:0] presc, input logic c2x, input logic dord,
                      input int coll_at, input int abort_at, input int rst_at);
    int h, last, k, j, jm, n_we, e_busy, e_ssn, e_sck, e_we, e_if, e_wc;
    logic cpol, cpha, x_busy, x_ssn, x_sck, x_we, x_wc, cut;
    logic [7:0] got;
    h = htab[{c2x, presc}];
    last = 16 * h + 8;
    cpol = mode[1];
    cpha = mode[0];
    n_we = 0; e_busy = 0; e_ssn = 0; e_sck = 0; e_we = 0; e_if = 0; e_wc = 0;
    got = 8'h00;
    @(negedge clk);
    ctrl_enable = 1'b1; ctrl_master = 1'b1; ctrl_mode = mode;
    ctrl_prescaler = presc; ctrl_clk2x = c2x; ctrl_dord = dord;
    tx_data = tx; tx_wr = 1'b1;
    miso = rxb[dord ? 0 : 7];
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      tx_wr = 1'b0;
      rst = 1'b0;
      cut = (abort_at >= 0 && n >= abort_at) || (rst_at >= 0 && n >= rst_at);
      x_we = 1'b0;
      if (rst_at >= 0 && n == rst_at) begin
        x_busy = 1'b0; x_ssn = 1'b1; x_sck = 1'b0;
        chk("rst_rdata", 32'(rdata_next), 32'h0);
        chk("rst_mosi_sck", {30'd0, mosi, sck}, 32'h0);
      end else if (cut || n > 16 * h) begin
        x_busy = 1'b0; x_ssn = 1'b1; x_sck = cpol;
      end else if (n == 16 * h) begin
        x_busy = 1'b1; x_ssn = 1'b0; x_sck = cpol; x_we = 1'b1;
      end else begin
        x_busy = 1'b1; x_ssn = 1'b0; x_sck = cpol ^ ((n / h) % 2 == 1);
      end
      x_wc = (n == coll_at);
      if (busy !== x_busy) e_busy++;
      if (ss_n !== x_ssn) e_ssn++;
      if (sck !== x_sck) e_sck++;
      if (rdata_we !== x_we) e_we++;
      if (if_we !== x_we) e_if++;
      if (wrcol_we !== x_wc) e_wc++;
      if (rdata_we === 1'b1) n_we++;
      if (x_we) chk("rdata", 32'(rdata_next), 32'(rxb));
      // sample mosi just before a sampling sck edge
      if ((n + 1) % h == 0) begin
        k = (n + 1) / h;
        if (k >= 1 + cpha && k <= 16 && ((k - 1 - cpha) % 2 == 0)) begin
          j = (k - 1 - cpha) / 2;
          got[dord ? j : 7 - j] = mosi;
        end
      end
      // slave presents the bit for the next sampling edge not yet passed
      jm = 0;
      for (int kk = 1 + cpha; kk <= 16; kk += 2) if (kk * h <= n) jm++;
      miso = (jm < 8) ? rxb[dord ? jm : 7 - jm] : 1'b0;
      if (n + 1 == coll_at) begin tx_wr = 1'b1; tx_data = 8'($urandom); end
      if (n + 1 == abort_at) ctrl_enable = 1'b0;
      if (n + 1 == rst_at) rst = 1'b1;
    end
    ctrl_enable = 1'b1;
    rst = 1'b0;
    chk("busy_wave", 32'(e_busy), 32'd0);
    chk("ssn_wave", 32'(e_ssn), 32'd0);
    chk("sck_wave", 32'(e_sck), 32'd0);
    chk("rdata_we_wave", 32'(e_we), 32'd0);
    chk("if_we_wave", 32'(e_if), 32'd0);
    chk("wrcol_wave", 32'(e_wc), 32'd0);
    chk("rdata_we_count", 32'(n_we), (abort_at >= 0 || rst_at >= 0) ? 32'd0 : 32'd1);
    if (abort_at < 0 && rst_at < 0) chk("mosi_byte", 32'(got), 32'(tx));
  endtask

  // tx_wr that must be ignored; the bus must stay quiet with no collision.
  task automatic gated(input logic en, input logic ms, input string tag);
    int errs;
    errs = 0;
    @(negedge clk);
    ctrl_enable = en; ctrl_master = ms; ctrl_mode = 2'd0;
    tx_data = 8'($urandom); tx_wr = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      tx_wr = 1'b0;
      if (busy !== 1'b0 || ss_n !== 1'b1 || wrcol_we !== 1'b0 || rdata_we !== 1'b0 || sck !== 1'b0)
        errs++;
    end
    ctrl_enable = 1'b1; ctrl_master = 1'b1;
    chk(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    logic [1:0] rm, rp;
    logic       rc, rd;
    int         hh, ca;
    rst = 1'b1;
    ctrl_enable = 1'b0; ctrl_master = 1'b0; ctrl_mode = 2'd0;
    ctrl_prescaler = 2'd0; ctrl_clk2x = 1'b0; ctrl_dord = 1'b0;
    intctrl_intlvl = 2'd0; status_if = 1'b0;
    tx_wr = 1'b0; tx_data = 8'h00; miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sck", 32'(sck), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_ssn", 32'(ss_n), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", 32'(rdata_next), 32'd0);
    chk("reset_pulses", {29'd0, rdata_we, if_we, wrcol_we}, 32'd0);
    chk("const_next", {30'd0, if_next, wrcol_next}, 32'd3);
    rst = 1'b0;
    ctrl_enable = 1'b1; ctrl_master = 1'b1;
    @(negedge clk);

    // basic MSB-first, miso looped back
    xfer(8'hA5, 8'hA5, 2'd0, 2'd0, 1'b0, 1'b0, -1, -1, -1);
    // LSB-first, mode3, H=4
    xfer(8'h01, 8'h80, 2'd3, 2'd1, 1'b1, 1'b1, -1, -1, -1);
    // write collision mid-transfer
    xfer(8'h3C, 8'h5A, 2'd0, 2'd0, 1'b0, 1'b0, 10, -1, -1);
    // abort by dropping enable
    xfer(8'hC3, 8'h96, 2'd1, 2'd0, 1'b0, 1'b0, -1, 7, -1);
    // reset mid-transfer, then a normal transfer
    xfer(8'h7E, 8'h42, 2'd2, 2'd0, 1'b0, 1'b0, -1, -1, 5);
    xfer(8'h81, 8'hE7, 2'd2, 2'd0, 1'b0, 0, -1, -1, -1);

    gated(1'b1, 1'b0, "gate_master");
    gated(1'b0, 1'b1, "gate_enable");

    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 4; l++) begin
        status_if = s[0]; intctrl_intlvl = l[1:0];
        #1;
        chk("irq", 32'(irq), 32'((s == 1) && (l != 0)));
      end
    status_if = 1'b0; intctrl_intlvl = 2'd0;

    for (int t = 0; t < 12; t++) begin
      rm = 2'($urandom); rp = 2'($urandom); rc = 1'($urandom); rd = 1'($urandom);
      hh = htab[{rc, rp}];
      ca = ($urandom % 3 == 0) ? int'($urandom_range(1, 16 * hh + 1)) : -1;
      xfer(8'($urandom), 8'($urandom), rm, rp, rc, rd, ca, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
